wb_sched: RTL and testbench

WB_SCHED -- requirements
Module: wb_sched

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_sched_if.sv | 31 +++
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/wb_sched.sv | 84 ++++++++
 tb/tb_wb_sched.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the write-back scheduler: default sizes, register-file geometry
// and requester index assignments.
package wb_pkg;

    localparam int unsigned DEF_NREQ = 3;
    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREGS    = 32;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_MUL  = 2;

endpackage

// File: rtl/wb_sched_if.sv
// Write-back scheduler bus: requester handshakes, issue reservation, scoreboard and the
// registered register-file write port. master = requesters/decode side, slave = scheduler.
interface wb_sched_if import wb_pkg::*; #(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned XLEN = DEF_XLEN
) ();

    logic [NREQ-1:0]        req_valid;
    logic [REG_AW*NREQ-1:0] req_rd;
    logic [XLEN*NREQ-1:0]   req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wb_hold;
    logic                   issue_valid;
    logic [REG_AW-1:0]      issue_rd;
    logic                   issue_ready;
    logic [NREGS-1:0]       busy;
    logic                   regwrite;
    logic [REG_AW-1:0]      write_reg;
    logic [XLEN-1:0]        write_data;

    modport master (
        output req_valid, req_rd, req_data, wb_hold, issue_valid, issue_rd,
        input  req_ready, issue_ready, busy, regwrite, write_reg, write_data
    );

    modport slave (
        input  req_valid, req_rd, req_data, wb_hold, issue_valid, issue_rd,
        output req_ready, issue_ready, busy, regwrite, write_reg, write_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant arbiter. With WB_SCHED_RR_EN defined it is round-robin (search starts after
// the last grant); otherwise it is fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
`ifdef WB_SCHED_RR_EN
    input  logic            clk,
    input  logic            reset,
`endif
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    output logic [NREQ-1:0] grant
);

    logic found;

`ifdef WB_SCHED_RR_EN
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    int unsigned   idx;

    // Every grant is accepted (grants only go to valid requesters), so the pointer
    // follows the grant directly.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (!hold) begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                idx = (32'(ptr_q) + i) % NREQ;
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    ptr_d      = PW'(idx);
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (!hold) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: arbitrates result requesters onto one register-file write port and
// keeps the destination-register scoreboard. Optional macro: WB_SCHED_RR_EN (round-robin).
module wb_sched import wb_pkg::*; #(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned XLEN = DEF_XLEN
) (
    input logic       clk,
    input logic       reset,
    wb_sched_if.slave bus
);

    logic [NREQ-1:0]   grant;
    logic              accept;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    logic              regwrite_q;
    logic [REG_AW-1:0] write_reg_q;
    logic [XLEN-1:0]   write_data_q;
    logic [NREGS-1:0]  busy_q, busy_d;

    // Reset doubles as a hold so nothing is granted while it is asserted.
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
`ifdef WB_SCHED_RR_EN
        .clk   (clk),
        .reset (reset),
`endif
        .req   (bus.req_valid),
        .hold  (bus.wb_hold | reset),
        .grant (grant)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd | bus.req_rd[REG_AW*i +: REG_AW];
                sel_data = sel_data | bus.req_data[XLEN*i +: XLEN];
            end
        end
    end

    assign bus.issue_ready = reset || (bus.issue_rd == '0) || !busy_q[bus.issue_rd];

    // Clear from the retiring write first so a same-edge reservation of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (regwrite_q) begin
            busy_d[write_reg_q] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            regwrite_q <= accept && (sel_rd != '0);
            if (accept) begin
                write_reg_q  <= sel_rd;
                write_data_q <= sel_data;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.regwrite   = regwrite_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: directed scenarios plus random traffic, compared
// against a register-level behavioural model through an expectation queue.
module tb_wb_sched;
    import wb_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_sched_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

    wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus for the next cycle
    bit              s_rst, s_hold, s_iv;
    logic [NREQ-1:0] s_valid;
    logic [4:0]      s_rd   [NREQ];
    logic [31:0]     s_data [NREQ];
    logic [4:0]      s_ird;

    // Reference model: architectural view of the scheduler
    bit          m_wr;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    bit          m_bsy [32];
    int          m_last;

    typedef struct {
        bit          wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] busy;
    } exp_t;
    exp_t exp_q[$];

    int               last_g = -1;
    logic [NREQ-1:0]  obs_ready;
    logic             obs_iready;

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_bsy[r];
        return v;
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v);
`ifdef WB_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (v[idx]) return idx;
        end
`else
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    // Called at a negedge: apply stimulus, check combinational outputs, advance the model.
    task automatic step();
        int   g;
        bit   ir;
        exp_t e;
        reset           = s_rst;
        bus.wb_hold     = s_hold;
        bus.req_valid   = s_valid;
        bus.issue_valid = s_iv;
        bus.issue_rd    = s_ird;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_rd[5*i +: 5]       = s_rd[i];
            bus.req_data[XLEN*i +: XLEN] = s_data[i];
        end
        #1;
        g  = (s_rst || s_hold) ? -1 : model_grant(s_valid);
        ir = s_rst || (s_ird == 0) || !m_bsy[s_ird];
        obs_ready  = bus.req_ready;
        obs_iready = bus.issue_ready;
        check("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
        check("issue_ready", bus.issue_ready, ir);
        if (s_rst) begin
            m_wr = 0; m_wreg = 0; m_wdata = 0; m_last = NREQ - 1;
            for (int r = 0; r < 32; r++) m_bsy[r] = 0;
        end else begin
            bit nb [32];
            nb = m_bsy;
            if (m_wr) nb[m_wreg] = 0;
            if (s_iv && ir && s_ird != 0) nb[s_ird] = 1;
            m_bsy = nb;
            if (g >= 0) begin
                m_wr    = (s_rd[g] != 0);
                m_wreg  = s_rd[g];
                m_wdata = s_data[g];
                m_last  = g;
            end else begin
                m_wr = 0;
            end
        end
        e.wr = m_wr; e.wreg = m_wreg; e.wdata = m_wdata; e.busy = busy_vec();
        exp_q.push_back(e);
        last_g = g;
        @(negedge clk);
    endtask

    // Monitor: compare registered outputs against the queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("regwrite", bus.regwrite, e.wr);
                check("write_reg", bus.write_reg, e.wreg);
                check("write_data", bus.write_data, e.wdata);
                check("busy", bus.busy, e.busy);
            end
        end
    end

    task automatic idle();
        s_rst = 0; s_hold = 0; s_iv = 0; s_ird = 0; s_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_rd[i] = 0; s_data[i] = 0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp [6];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        m_last = NREQ - 1;
        idle();
        @(negedge clk);

        // Reset, with a reservation attempted during reset that must be dropped
        s_rst = 1;
        step();
        s_iv = 1; s_ird = 4;
        step();
        check("rst_regwrite", bus.regwrite, 0);
        check("rst_write_reg", bus.write_reg, 0);
        check("rst_write_data", bus.write_data, 0);
        check("rst_busy", bus.busy, 0);

        // Reserve r5 twice
        idle(); s_iv = 1; s_ird = 5;
        step();
        check("busy_after_rd5", bus.busy, 32'h0000_0020);
        step();
        check("issue_ready_rd5_again", obs_iready, 0);

        // All requesters valid for six cycles
        idle(); s_valid = '1;
        for (int c = 0; c < 6; c++) begin
            step();
`ifdef WB_SCHED_RR_EN
            check("rr_grant", obs_ready, rr_exp[c]);
`else
            check("fixed_grant", obs_ready, 3'b001);
`endif
        end

        // Write-back of a reserved register clears busy one edge after regwrite
        idle(); s_iv = 1; s_ird = 7;
        step();
        idle(); s_valid = 3'b010; s_rd[REQ_LOAD] = 7; s_data[REQ_LOAD] = 32'hDEAD_BEEF;
        step();
        check("wb7_ready", obs_ready, 3'b010);
        check("wb7_regwrite", bus.regwrite, 1);
        check("wb7_write_reg", bus.write_reg, 7);
        check("wb7_write_data", bus.write_data, 32'hDEAD_BEEF);
        check("wb7_busy_still", bus.busy[7], 1);
        idle();
        step();
        check("wb7_busy_cleared", bus.busy[7], 0);

        // Reservation of r9 on the same edge as its write-back: set wins
        idle(); s_valid = 3'b001; s_rd[REQ_ALU] = 9; s_data[REQ_ALU] = 32'h1234_5678;
        step();
        idle(); s_iv = 1; s_ird = 9;
        step();
        check("set_wins_busy9", bus.busy[9], 1);

        // Write to r0 consumes the slot without a register write
        idle(); s_valid = 3'b001; s_rd[REQ_ALU] = 0; s_data[REQ_ALU] = 32'hFFFF_FFFF;
        step();
        check("rd0_ready", obs_ready, 3'b001);
        check("rd0_regwrite", bus.regwrite, 0);
        idle(); s_hold = 1; s_valid = '1;
        step();
        check("hold_ready", obs_ready, 0);
        check("hold_regwrite", bus.regwrite, 0);

        // Reset right after an accept discards the pending write
        idle(); s_valid = 3'b001; s_rd[REQ_ALU] = 3; s_data[REQ_ALU] = 32'h0000_0033;
        step();
        idle(); s_rst = 1;
        step();
        check("rst_after_accept_regwrite", bus.regwrite, 0);
        check("rst_after_accept_busy", bus.busy, 0);
        idle();
        step();
        check("post_rst_regwrite", bus.regwrite, 0);

        // Random traffic; a stalled requester keeps its rd/data stable
        for (int c = 0; c < 2000; c++) begin
            s_rst  = ($urandom_range(0, 63) == 0);
            s_hold = ($urandom_range(0, 9) == 0);
            s_iv   = $urandom_range(0, 1);
            s_ird  = 5'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (!(s_valid[i] && last_g != i)) begin
                    s_valid[i] = ($urandom_range(0, 9) < 6);
                    s_rd[i]    = 5'($urandom_range(0, 15));
                    s_data[i]  = $urandom;
                end
            end
            step();
        end

        idle();
        step();
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
